// File: rtl/alu_muldiv_seq.sv
// Sequential RV32M unsigned MUL/MULHU/DIVU/REMU unit that borrows the shared
// execute-stage ALU for one shift-add or restoring-divide pass per clock.
module alu_muldiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic [31:0] AluA,
   output logic [31:0] AluB,
   output logic [1:0]  AluControl,
   input  logic [31:0] AluResult,
   input  logic        AluCarryOut,
   output logic        busy,
   output logic        done,
   output logic [31:0] Result
);

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b10;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULHU = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_REMU  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;        // product high word / partial remainder
   logic [31:0] lo_q, lo_d;        // multiplier-product low word / quotient
   logic [31:0] opb_q, opb_d;      // multiplicand or divisor
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;

   logic        is_div;
   logic        div_msb;
   logic [31:0] div_rsh;
   logic [31:0] hi_step, lo_step;

   assign is_div  = op_q[1];
   // Remainder shifted left by one with the next dividend bit; the bit shifted
   // out is the 33rd bit that forces a subtraction regardless of the borrow.
   assign div_msb = hi_q[31];
   assign div_rsh = {hi_q[30:0], lo_q[31]};

   assign AluA       = (state_q == S_RUN) ? (is_div ? div_rsh : hi_q) : 32'd0;
   assign AluB       = (state_q == S_RUN) ? opb_q : 32'd0;
   assign AluControl = (state_q == S_RUN && is_div) ? ALU_SUB : ALU_ADD;

   assign busy   = busy_q;
   assign done   = done_q;
   assign Result = result_q;

   always_comb begin
      hi_step = hi_q;
      lo_step = lo_q;
      if (!is_div) begin
         if (lo_q[0]) begin
            hi_step = {AluCarryOut, AluResult[31:1]};
            lo_step = {AluResult[0], lo_q[31:1]};
         end else begin
            hi_step = {1'b0, hi_q[31:1]};
            lo_step = {hi_q[0], lo_q[31:1]};
         end
      end else begin
         if (div_msb || !AluCarryOut) begin
            hi_step = AluResult;
            lo_step = {lo_q[30:0], 1'b1};
         end else begin
            hi_step = div_rsh;
            lo_step = {lo_q[30:0], 1'b0};
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = op;
               opb_d  = SrcB;
               cnt_d  = 5'd0;
               hi_d   = 32'd0;
               lo_d   = SrcA;
               busy_d = 1'b1;
               if (op[1] && SrcB == 32'd0) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  result_d = op[0] ? SrcA : 32'hFFFF_FFFF;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               case (op_q)
                  OP_MUL:   result_d = lo_step;
                  OP_MULHU: result_d = hi_step;
                  OP_DIVU:  result_d = lo_step;
                  OP_REMU:  result_d = hi_step;
                  default:  result_d = lo_step;
               endcase
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= 2'b00;
         cnt_q    <= 5'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         opb_q    <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq; models the shared 32-bit ALU and checks
// results, latency, busy/done framing and ALU ownership.
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] SrcA, SrcB;
   logic [31:0] AluA, AluB;
   logic [1:0]  AluControl;
   logic [31:0] AluResult;
   logic        AluCarryOut;
   logic        busy, done;
   logic [31:0] Result;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_muldiv_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .SrcA(SrcA), .SrcB(SrcB),
      .AluA(AluA), .AluB(AluB), .AluControl(AluControl),
      .AluResult(AluResult), .AluCarryOut(AluCarryOut),
      .busy(busy), .done(done), .Result(Result)
   );

   // Shared ALU: ADD carry = bit 32 of sum, SUB carry = borrow (A < B).
   logic [32:0] alu_wide;
   always_comb begin
      alu_wide = 33'd0;
      if (AluControl == 2'b00) alu_wide = {1'b0, AluA} + {1'b0, AluB};
      else                     alu_wide = {1'b0, AluA} - {1'b0, AluB};
   end
   assign AluResult   = alu_wide[31:0];
   assign AluCarryOut = alu_wide[32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int cyc;
      @(negedge clk);
      start = 1'b1; op = o; SrcA = a; SrcB = b;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 45) begin
         chk({tag, " busy_run"}, {31'd0, busy}, 32'd1);
         chk({tag, " aluctl"}, {30'd0, AluControl}, o[1] ? 32'd2 : 32'd0);
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, cyc, exp_lat);
      chk({tag, " busy_done"}, {31'd0, busy}, 32'd1);
      chk({tag, " result"}, Result, exp_res);
      $display("op=%0d A=%h B=%h -> Result=%h latency=%0d", o, a, b, Result, cyc);
      @(negedge clk);
      chk({tag, " done_clr"}, {31'd0, done}, 32'd0);
      chk({tag, " busy_clr"}, {31'd0, busy}, 32'd0);
      chk({tag, " result_hold"}, Result, exp_res);
      chk({tag, " aluA_idle"}, AluA, 32'd0);
      chk({tag, " aluctl_idle"}, {30'd0, AluControl}, 32'd0);
   endtask

   initial begin
      int cyc;
      int n_done;
      reset = 1'b1; start = 1'b0; op = 2'b00; SrcA = 32'd0; SrcB = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst result", Result, 32'd0);
      chk("rst aluA", AluA, 32'd0);
      chk("rst aluB", AluB, 32'd0);
      chk("rst aluctl", {30'd0, AluControl}, 32'd0);
      reset = 1'b0;

      do_op("mul7x6",      2'b00, 32'd7,          32'd6,          32'h0000_002A, 33);
      do_op("mulhu_ff",    2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33);
      do_op("mul_ff",      2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 33);
      do_op("mulhu_2p33",  2'b01, 32'h8000_0000,  32'd4,          32'h0000_0002, 33);
      do_op("divu100_7",   2'b10, 32'd100,        32'd7,          32'h0000_000E, 33);
      do_op("remu100_7",   2'b11, 32'd100,        32'd7,          32'h0000_0002, 33);
      do_op("divu_ff_1",   2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 33);
      do_op("remu_ff_1",   2'b11, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, 33);
      do_op("divu_2p31_3", 2'b10, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA, 33);
      do_op("remu_2p31_3", 2'b11, 32'h8000_0000,  32'd3,          32'h0000_0002, 33);
      do_op("divu_by0",    2'b10, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF, 1);
      do_op("remu_by0",    2'b11, 32'h0000_1234,  32'd0,          32'h0000_1234, 1);

      // Reset partway through a multiply discards it.
      @(negedge clk);
      start = 1'b1; op = 2'b00; SrcA = 32'd5; SrcB = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("midrun busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst busy", {31'd0, busy}, 32'd0);
      chk("midrst done", {31'd0, done}, 32'd0);
      chk("midrst result", Result, 32'd0);
      chk("midrst aluA", AluA, 32'd0);
      chk("midrst aluB", AluB, 32'd0);
      n_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      chk("midrst no_done", n_done, 0);
      do_op("divu_after_rst", 2'b10, 32'd100, 32'd7, 32'h0000_000E, 33);

      // start pulses during RUN and DONE are ignored.
      @(negedge clk);
      start = 1'b1; op = 2'b00; SrcA = 32'd3; SrcB = 32'd5;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 45) begin
         if (cyc == 5) begin
            start = 1'b1; op = 2'b01; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      chk("ign latency", cyc, 33);
      chk("ign result", Result, 32'h0000_000F);
      $display("op=0 A=00000003 B=00000005 (start pulsed in RUN) -> Result=%h latency=%0d", Result, cyc);
      start = 1'b1; op = 2'b10; SrcA = 32'd100; SrcB = 32'd7;
      @(negedge clk);
      start = 1'b0;
      chk("ign_done busy", {31'd0, busy}, 32'd0);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      chk("ign_done no_done", n_done, 0);
      chk("ign_done result_hold", Result, 32'h0000_000F);
      chk("ign_done busy_idle", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
